// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - endpoint register map and TX DMA loader state type
package chiplet_types_pkg;

  // Endpoint register map, shared with the endpoint itself
  localparam logic [31:0] TX_SEND_ADDR        = 32'h0000_1004;
  localparam logic [31:0] TX_CACHE_START_ADDR = 32'h0000_2000;
  localparam logic [31:0] PKT_ADDR_BASE       = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    SET_PTR,
    SEND,
    DONE,
    ERR
  } dma_state_t;

endpackage

// File: rtl/tx_dma_loader.sv
// rtl/tx_dma_loader.sv - turns a streamed packet plus descriptor into endpoint TX register writes
module tx_dma_loader
  import chiplet_types_pkg::*;
#(
  parameter int NUM_MSGS        = 4,
  parameter int CACHE_NUM_WORDS = 128,
  parameter int MAX_LEN_W       = 8,
  localparam int MSG_W          = $clog2(NUM_MSGS),
  localparam int OFF_W          = $clog2(4 * CACHE_NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [MSG_W-1:0]     msg_id,
  input  logic [OFF_W-1:0]     cache_offset,
  input  logic [MAX_LEN_W-1:0] num_words,
  input  logic                 data_valid,
  input  logic [31:0]          data,
  output logic                 data_ready,
  output logic [31:0]          bus_addr,
  output logic                 bus_wen,
  output logic                 bus_ren,
  output logic [31:0]          bus_wdata,
  output logic [3:0]           bus_strobe,
  input  logic [31:0]          bus_rdata,
  input  logic                 bus_error,
  input  logic                 bus_request_stall,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [31:0]          CACHE_BYTES = 32'(4 * CACHE_NUM_WORDS);
  localparam logic [MAX_LEN_W-1:0] LEN_ONE     = MAX_LEN_W'(1);

  dma_state_t           state_q, state_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [MSG_W-1:0]     msg_q, msg_d;
  logic [MAX_LEN_W-1:0] len_q, len_d;
  logic [MAX_LEN_W-1:0] idx_q, idx_d;

  logic [OFF_W-1:0]     off_aligned;
  logic [31:0]          desc_end;
  logic                 unused_inputs;

  // The cache is word addressed, so the byte offset is forced to a word boundary
  assign off_aligned   = {cache_offset[OFF_W-1:2], 2'b00};
  assign desc_end      = 32'(off_aligned) + 32'({num_words, 2'b00});
  assign unused_inputs = ^{bus_rdata, cache_offset[1:0]};

  assign bus_ren    = 1'b0;
  assign bus_strobe = bus_wen ? 4'hF : 4'h0;
  assign busy       = n_rst && (state_q != IDLE);

  // Next state, latched descriptor fields and bus outputs; outputs are quiet while in reset
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    msg_d      = msg_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_ready = 1'b0;
    bus_addr   = 32'h0;
    bus_wen    = 1'b0;
    bus_wdata  = 32'h0;
    done       = 1'b0;
    err        = 1'b0;
    if (n_rst) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (desc_end > CACHE_BYTES) begin
              state_d = ERR;
            end else begin
              off_d   = off_aligned;
              msg_d   = msg_id;
              len_d   = num_words;
              idx_d   = '0;
              state_d = (num_words == '0) ? SET_PTR : DATA;
            end
          end
        end
        DATA: begin
          bus_wen    = data_valid;
          bus_addr   = TX_CACHE_START_ADDR + 32'(off_q) + 32'({idx_q, 2'b00});
          bus_wdata  = data;
          // An errored word is still taken from the stream
          data_ready = data_valid & ~bus_request_stall;
          if (data_valid && !bus_request_stall) begin
            if (bus_error) begin
              state_d = ERR;
            end else begin
              idx_d = idx_q + LEN_ONE;
              if (idx_q == len_q - LEN_ONE) state_d = SET_PTR;
            end
          end
        end
        SET_PTR: begin
          bus_wen   = 1'b1;
          bus_addr  = PKT_ADDR_BASE + 32'({msg_q, 2'b00});
          bus_wdata = 32'(off_q);
          if (!bus_request_stall) state_d = bus_error ? ERR : SEND;
        end
        SEND: begin
          bus_wen   = 1'b1;
          bus_addr  = TX_SEND_ADDR;
          bus_wdata = 32'(msg_q);
          if (!bus_request_stall) state_d = bus_error ? ERR : DONE;
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        ERR: begin
          err     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and descriptor registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_tx_dma_loader.sv
// tb/tb_tx_dma_loader.sv - directed self-checking bench for tx_dma_loader
module tb_tx_dma_loader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  msg_id = '0;
  logic [8:0]  cache_offset = '0;
  logic [7:0]  num_words = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data = '0;
  logic        data_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_rdata = '0;
  logic        bus_error = 1'b0;
  logic        bus_request_stall = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  int          cyc_cnt = 0;
  int          wen_cycles = 0;
  int          strobe_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          done_cyc = 0;
  int          log_n = 0;
  logic [31:0] log_addr [0:127];
  logic [31:0] log_data [0:127];
  int          log_cyc  [0:127];

  tx_dma_loader dut (
    .clk(clk), .n_rst(n_rst), .start(start), .msg_id(msg_id),
    .cache_offset(cache_offset), .num_words(num_words),
    .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
    .bus_wdata(bus_wdata), .bus_strobe(bus_strobe), .bus_rdata(bus_rdata),
    .bus_error(bus_error), .bus_request_stall(bus_request_stall),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Bus monitor: logs every completed access and counts pulses
  always @(posedge clk) begin
    cyc_cnt++;
    if (n_rst) begin
      if (bus_wen) begin
        wen_cycles++;
        if (bus_strobe != 4'hF) strobe_bad++;
      end
      if (bus_wen && !bus_request_stall && log_n < 128) begin
        log_addr[log_n] = bus_addr;
        log_data[log_n] = bus_wdata;
        log_cyc[log_n]  = cyc_cnt;
        log_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (err) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(input int i, input logic [31:0] a, input logic [31:0] d);
    check_eq($sformatf("wr%0d_addr", i), (i < log_n) ? log_addr[i] : 32'hDEAD_BEEF, a);
    check_eq($sformatf("wr%0d_data", i), (i < log_n) ? log_data[i] : 32'hDEAD_BEEF, d);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_wen"}, 32'(bus_wen), 32'h0);
    check_eq({tag, "_ready"}, 32'(data_ready), 32'h0);
    check_eq({tag, "_addr"}, bus_addr, 32'h0);
    check_eq({tag, "_wdata"}, bus_wdata, 32'h0);
    check_eq({tag, "_done_err"}, {30'b0, done, err}, 32'h0);
  endtask

  // Issue one descriptor and feed its stream; optional stall on one word and error on one address
  task automatic run_desc(input logic [1:0] m, input logic [8:0] off, input logic [7:0] n,
                          input logic [31:0] base, input int stall_word, input int stall_n,
                          input logic err_on, input logic [31:0] err_addr);
    int ptr;
    int sl;
    int cyc;
    int d0;
    int e0;
    ptr = 0;
    sl  = stall_n;
    cyc = 0;
    d0  = done_cnt;
    e0  = err_cnt;
    @(negedge clk);
    start = 1'b1; msg_id = m; cache_offset = off; num_words = n;
    @(negedge clk);
    start = 1'b0;
    while (done_cnt == d0 && err_cnt == e0 && cyc < 200) begin
      data_valid = (ptr < int'(n));
      data = base + 32'(ptr);
      bus_request_stall = (ptr == stall_word) && (sl > 0);
      #1;
      bus_error = err_on && bus_wen && !bus_request_stall && (bus_addr == err_addr);
      #1;
      if (bus_request_stall) begin
        sl--;
        check_eq("stall_addr", bus_addr, 32'h2000 + {23'b0, off[8:2], 2'b00} + 32'(4 * ptr));
        check_eq("stall_wdata", bus_wdata, base + 32'(ptr));
        check_eq("stall_ready", 32'(data_ready), 32'h0);
      end
      if (data_ready) ptr++;
      @(negedge clk);
      cyc++;
    end
    data_valid = 1'b0;
    bus_request_stall = 1'b0;
    bus_error = 1'b0;
    check_eq("run_completes", 32'(cyc < 200), 32'h1);
  endtask

  initial begin
    int s;
    int w;
    int d0;
    int e0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset_low");
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("reset");
    check_eq("reset_ren_strobe", {27'b0, bus_ren, bus_strobe}, 32'h0);

    // Basic three-word send
    s = log_n; w = wen_cycles;
    run_desc(2'd2, 9'h010, 8'd3, 32'hA0, -1, 0, 1'b0, 32'h0);
    check_eq("t1_nwr", 32'(log_n - s), 32'd5);
    exp_wr(s + 0, 32'h2010, 32'hA0);
    exp_wr(s + 1, 32'h2014, 32'hA1);
    exp_wr(s + 2, 32'h2018, 32'hA2);
    exp_wr(s + 3, 32'h0008, 32'h10);
    exp_wr(s + 4, 32'h1004, 32'h2);
    check_eq("t1_wen_cycles", 32'(wen_cycles - w), 32'd5);
    check_eq("t1_latency", 32'(done_cyc - log_cyc[s]), 32'd5);
    check_eq("t1_busy_after", 32'(busy), 32'h0);

    // Same descriptor with a two-cycle stall on the second word
    s = log_n; w = wen_cycles;
    run_desc(2'd2, 9'h010, 8'd3, 32'hA0, 1, 2, 1'b0, 32'h0);
    check_eq("t2_nwr", 32'(log_n - s), 32'd5);
    exp_wr(s + 0, 32'h2010, 32'hA0);
    exp_wr(s + 1, 32'h2014, 32'hA1);
    exp_wr(s + 2, 32'h2018, 32'hA2);
    exp_wr(s + 3, 32'h0008, 32'h10);
    exp_wr(s + 4, 32'h1004, 32'h2);
    check_eq("t2_wen_cycles", 32'(wen_cycles - w), 32'd7);

    // Zero-length packet
    s = log_n; d0 = done_cnt;
    run_desc(2'd1, 9'h000, 8'd0, 32'h0, -1, 0, 1'b0, 32'h0);
    check_eq("t3_nwr", 32'(log_n - s), 32'd2);
    exp_wr(s + 0, 32'h0004, 32'h0);
    exp_wr(s + 1, 32'h1004, 32'h1);
    check_eq("t3_done", 32'(done_cnt - d0), 32'd1);

    // Overrun past the end of the cache is rejected
    w = wen_cycles; e0 = err_cnt;
    @(negedge clk);
    start = 1'b1; msg_id = 2'd3; cache_offset = 9'h1F0; num_words = 8'd5;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_err_pulse", 32'(err), 32'h1);
    @(negedge clk);
    check_eq("t4_err_once", 32'(err), 32'h0);
    check_eq("t4_busy_after", 32'(busy), 32'h0);
    check_eq("t4_no_wen", 32'(wen_cycles - w), 32'd0);
    check_eq("t4_err_cnt", 32'(err_cnt - e0), 32'd1);

    // Exactly filling the cache tail is accepted
    s = log_n;
    run_desc(2'd2, 9'h1F0, 8'd4, 32'hE0, -1, 0, 1'b0, 32'h0);
    check_eq("t5_nwr", 32'(log_n - s), 32'd6);
    exp_wr(s + 3, 32'h21FC, 32'hE3);
    exp_wr(s + 4, 32'h0008, 32'h1F0);

    // Bus error on the start-pointer write aborts before the send trigger
    s = log_n; d0 = done_cnt; e0 = err_cnt;
    run_desc(2'd3, 9'h020, 8'd1, 32'hD0, -1, 0, 1'b1, 32'h000C);
    check_eq("t6_nwr", 32'(log_n - s), 32'd2);
    exp_wr(s + 1, 32'h000C, 32'h20);
    check_eq("t6_err", 32'(err_cnt - e0), 32'd1);
    check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t6_busy_after", 32'(busy), 32'h0);
    s = log_n;
    run_desc(2'd2, 9'h010, 8'd3, 32'hA0, -1, 0, 1'b0, 32'h0);
    check_eq("t6_recover_nwr", 32'(log_n - s), 32'd5);
    exp_wr(s + 4, 32'h1004, 32'h2);

    // Reset in the middle of DATA
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    start = 1'b1; msg_id = 2'd1; cache_offset = 9'h040; num_words = 8'd3;
    @(negedge clk);
    start = 1'b0; data_valid = 1'b1; data = 32'hB0;
    @(negedge clk);
    data = 32'hB1; n_rst = 1'b0;
    #1;
    check_eq("t7_ready_in_reset", 32'(data_ready), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check_idle("t7_after_reset");
    data_valid = 1'b0;
    check_eq("t7_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    s = log_n;
    run_desc(2'd0, 9'h000, 8'd2, 32'hC0, -1, 0, 1'b0, 32'h0);
    check_eq("t7_nwr", 32'(log_n - s), 32'd4);
    exp_wr(s + 0, 32'h2000, 32'hC0);
    exp_wr(s + 1, 32'h2004, 32'hC1);
    exp_wr(s + 2, 32'h0000, 32'h0);
    exp_wr(s + 3, 32'h1004, 32'h0);

    check_eq("strobe_all_writes", 32'(strobe_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tx_dma_loader.md
Name: tx_dma_loader

Overview:
- Bus master that sits directly upstream of the endpoint's peripheral bus port. It turns a streamed packet plus a one-shot descriptor into the endpoint register-write sequence.
- Sequence: TX cache data words, then the pkt start address register, then the TX send trigger.
- Removes the need for the CPU to issue per-word stores when it launches a message.

Parameters:
- NUM_MSGS, 4, number of message slots in the endpoint; msg_id width is $clog2(NUM_MSGS).
- CACHE_NUM_WORDS, 128, TX cache size in words; byte offset width is $clog2(4*CACHE_NUM_WORDS) = 9.
- MAX_LEN_W, 8, width of the word-count field.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  descriptor strobe, sampled in IDLE only
- msg_id  in  $clog2(NUM_MSGS)  message slot to program and send
- cache_offset  in  9  byte offset into TX cache; low 2 bits are forced to 0
- num_words  in  MAX_LEN_W  packet length in 32-bit words
- data_valid  in  1  stream word present
- data  in  32  stream word
- data_ready  out  1  stream word consumed this cycle
- bus_addr  out  32  master address
- bus_wen  out  1  write request
- bus_ren  out  1  read request; tied 0
- bus_wdata  out  32  write data
- bus_strobe  out  4  byte enables; 4'hF on every write
- bus_rdata  in  32  unused
- bus_error  in  1  slave error, valid in the cycle the access completes
- bus_request_stall  in  1  slave stall; an access completes in a cycle with wen=1 and stall=0
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on successful send trigger
- err  out  1  one-cycle pulse on rejected descriptor or bus error

Behaviour:
- Reset: all state updates on posedge clk when n_rst=0 (synchronous). State becomes IDLE. All outputs are 0; bus_addr and bus_wdata are 0.
- Latched fields: addr_base = 32'h2000 + {cache_offset[8:2],2'b00}, msg, len, and a word counter idx (MAX_LEN_W bits) cleared to 0.
- IDLE:
  - start=1 with offset+4*num_words > 4*CACHE_NUM_WORDS → ERR.
  - start=1 with a valid descriptor → latch fields; go to DATA, or to SET_PTR if num_words=0.
  - start outside IDLE is ignored.
- DATA:
  - bus_wen = data_valid; bus_addr = addr_base + 4*idx; bus_wdata = data.
  - data_ready = data_valid & ~bus_request_stall.
  - On completion with bus_error=0: idx++. When idx = len-1 completes, go to SET_PTR.
  - On completion with bus_error=1 → ERR; the word counts as consumed (data_ready=1).
  - data_valid=0 → bus_wen=0 and the block waits with no timeout.
- SET_PTR:
  - bus_wen=1, bus_addr = 4*msg, bus_wdata = {23'b0, cache_offset aligned}.
  - Hold until not stalled. Complete → SEND; error → ERR.
- SEND:
  - bus_wen=1, bus_addr = 32'h1004, bus_wdata = msg zero-extended.
  - Complete → DONE; error → ERR.
- DONE: done=1 for one cycle → IDLE.
- ERR: err=1 for one cycle → IDLE. No further bus accesses are made for the aborted descriptor; already-written cache words are left as written.
- Bus discipline:
  - bus_addr, bus_wdata and bus_wen are held stable while bus_request_stall=1.
  - At most one access per cycle.
  - bus_wen is never asserted in IDLE, DONE or ERR.
- Latency with no stalls and data always valid: num_words + 2 bus cycles from the first DATA cycle; done follows one cycle after SEND completes.
- Reset mid-operation: returns to IDLE with no pulses and the stream unconsumed. Endpoint state is not rolled back.
- Counter width: len=0 never enters DATA, so idx never wraps.

Decomposition:
- chiplet_types_pkg holds the endpoint map constants, shared with the endpoint: TX_SEND_ADDR=32'h1004, TX_CACHE_START_ADDR=32'h2000, PKT_ADDR_BASE=32'h0.
- chiplet_types_pkg also holds the typedef enum dma_state_t {IDLE, DATA, SET_PTR, SEND, DONE, ERR}.
- Single module; no sub-module is warranted. Bus outputs are driven combinationally from state and the latched registers.

Test Plan:
- msg_id=2, offset=0x10, num_words=3, stream A0,A1,A2, no stall → writes 0x2010=A0, 0x2014=A1, 0x2018=A2, 0x8=0x10, 0x1004=2; done pulses; exactly 5 wen cycles.
- Same descriptor with stall=1 for 2 cycles on the second word → addr/wdata held at 0x2014/A1; data_ready low during the stall; the sequence otherwise matches the first test.
- num_words=0, msg_id=1, offset=0 → only 0x4=0 and 0x1004=1 are written; done pulses.
- offset=0x1F0, num_words=5 (overrun past 0x200) → err pulses the next cycle; no bus_wen ever asserted; busy low after.
- bus_error=1 on the SET_PTR write → err pulses; no write to 0x1004; returns to IDLE; a following valid descriptor completes normally.
- n_rst=0 for one cycle in the middle of DATA → next cycle busy=0 and all outputs 0; a new start then works from idx 0.
